// File: rtl/cnn_pkg.sv
// Shared types and helpers for the convolution datapath blocks.
`default_nettype none

package cnn_pkg;

  localparam int unsigned DATA_WIDTH_DEF = 8;
  localparam int unsigned ACC_WIDTH_DEF  = 32;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    STREAM   = 2'd1,
    WAIT_RES = 2'd2,
    OUTPUT   = 2'd3
  } streamer_state_e;

  // Index width for K elements, never narrower than one bit.
  function automatic int unsigned idx_width(input int unsigned k);
    return (k > 1) ? $clog2(k) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/kernel_reg_file.sv
// K kernel weights plus one bias word; writes are dropped while the streamer is busy.
`default_nettype none

module kernel_reg_file
  import cnn_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int unsigned ACC_WIDTH  = ACC_WIDTH_DEF,
  parameter int unsigned K          = 9,
  parameter int unsigned AW         = idx_width(K)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  wr_en_i,
  input  logic [AW:0]           wr_addr_i,
  input  logic [ACC_WIDTH-1:0]  wr_data_i,
  input  logic                  busy_i,
  input  logic [AW-1:0]         rd_idx_i,
  output logic [DATA_WIDTH-1:0] rd_weight_o,
  output logic [ACC_WIDTH-1:0]  bias_o
);

  localparam logic [AW:0] BIAS_ADDR = (AW + 1)'(K);

  logic [DATA_WIDTH-1:0] weight_q [K];
  logic [ACC_WIDTH-1:0]  bias_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(K); i++) begin
        weight_q[i] <= '0;
      end
      bias_q <= '0;
    end else if (wr_en_i && !busy_i) begin
      if (wr_addr_i < BIAS_ADDR) begin
        weight_q[wr_addr_i[AW-1:0]] <= wr_data_i[DATA_WIDTH-1:0];
      end else if (wr_addr_i == BIAS_ADDR) begin
        bias_q <= wr_data_i;
      end
    end
  end

  assign rd_weight_o = weight_q[rd_idx_i];
  assign bias_o      = bias_q;

endmodule

`default_nettype wire

// File: rtl/mac_operand_streamer.sv
// Serialises a KxK window with stored weights into a MAC, then returns MAC result plus bias.
`default_nettype none

module mac_operand_streamer
  import cnn_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = DATA_WIDTH_DEF,
  parameter int unsigned ACC_WIDTH     = ACC_WIDTH_DEF,
  parameter int unsigned KERNEL_SIZE_W = 3,
  parameter int unsigned KERNEL_SIZE_H = 3,
  localparam int unsigned K            = KERNEL_SIZE_W * KERNEL_SIZE_H,
  localparam int unsigned AW           = idx_width(K)
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    kernel_wr_en_i,
  input  logic [AW:0]             kernel_wr_addr_i,
  input  logic [ACC_WIDTH-1:0]    kernel_wr_data_i,
  output logic                    kernel_busy_o,
  input  logic                    window_valid_i,
  output logic                    window_ready_o,
  input  logic [K*DATA_WIDTH-1:0] window_data_i,
  output logic                    mac_in_valid_o,
  input  logic                    mac_in_ready_i,
  output logic [DATA_WIDTH-1:0]   mac_feature_o,
  output logic [DATA_WIDTH-1:0]   mac_weight_o,
  output logic                    mac_last_o,
  input  logic                    mac_valid_i,
  input  logic [ACC_WIDTH-1:0]    mac_data_i,
  output logic                    mac_ready_o,
  output logic                    result_valid_o,
  output logic [ACC_WIDTH-1:0]    result_data_o,
  input  logic                    result_ready_i
);

  localparam logic [AW-1:0] LAST_IDX = AW'(K - 1);

  streamer_state_e        state_q, state_d;
  logic [AW-1:0]          idx_q, idx_d;
  logic [K*DATA_WIDTH-1:0] window_q, window_d;
  logic [ACC_WIDTH-1:0]   result_q, result_d;
  logic [ACC_WIDTH-1:0]   bias_w;

  kernel_reg_file #(
    .DATA_WIDTH(DATA_WIDTH),
    .ACC_WIDTH (ACC_WIDTH),
    .K         (K),
    .AW        (AW)
  ) u_kernel_reg_file (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .wr_en_i    (kernel_wr_en_i),
    .wr_addr_i  (kernel_wr_addr_i),
    .wr_data_i  (kernel_wr_data_i),
    .busy_i     (kernel_busy_o),
    .rd_idx_i   (idx_q),
    .rd_weight_o(mac_weight_o),
    .bias_o     (bias_w)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      window_q <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      window_q <= window_d;
      result_q <= result_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    window_d = window_q;
    result_d = result_q;
    case (state_q)
      IDLE: begin
        if (window_valid_i) begin
          window_d = window_data_i;
          idx_d    = '0;
          state_d  = STREAM;
        end
      end
      STREAM: begin
        if (mac_in_ready_i) begin
          if (idx_q == LAST_IDX) begin
            idx_d   = '0;
            state_d = WAIT_RES;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      WAIT_RES: begin
        // Plain modular add: overflow wraps instead of saturating.
        if (mac_valid_i) begin
          result_d = mac_data_i + bias_w;
          state_d  = OUTPUT;
        end
      end
      OUTPUT: begin
        if (result_ready_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign kernel_busy_o  = (state_q != IDLE);
  assign window_ready_o = (state_q == IDLE);
  assign mac_in_valid_o = (state_q == STREAM);
  assign mac_feature_o  = window_q[idx_q*DATA_WIDTH +: DATA_WIDTH];
  assign mac_last_o     = (state_q == STREAM) && (idx_q == LAST_IDX);
  assign mac_ready_o    = (state_q == WAIT_RES);
  assign result_valid_o = (state_q == OUTPUT);
  assign result_data_o  = result_q;

endmodule

`default_nettype wire

// File: tb/tb_mac_operand_streamer.sv
// Scoreboard bench for mac_operand_streamer with a behavioural MAC on the far side.
`default_nettype none
`timescale 1ns/1ps

module tb_mac_operand_streamer;

  localparam int DW  = 8;
  localparam int ACC = 32;
  localparam int K   = 9;
  localparam int AW  = 4;

  logic            clk_i = 1'b0;
  logic            rst_ni = 1'b0;
  logic            kernel_wr_en_i = 1'b0;
  logic [AW:0]     kernel_wr_addr_i = '0;
  logic [ACC-1:0]  kernel_wr_data_i = '0;
  logic            kernel_busy_o;
  logic            window_valid_i = 1'b0;
  logic            window_ready_o;
  logic [K*DW-1:0] window_data_i = '0;
  logic            mac_in_valid_o;
  logic            mac_in_ready_i = 1'b1;
  logic [DW-1:0]   mac_feature_o;
  logic [DW-1:0]   mac_weight_o;
  logic            mac_last_o;
  logic            mac_valid_i = 1'b0;
  logic [ACC-1:0]  mac_data_i = '0;
  logic            mac_ready_o;
  logic            result_valid_o;
  logic [ACC-1:0]  result_data_o;
  logic            result_ready_i = 1'b1;

  always #5 clk_i = ~clk_i;

  mac_operand_streamer dut (
    .clk_i           (clk_i),
    .rst_ni          (rst_ni),
    .kernel_wr_en_i  (kernel_wr_en_i),
    .kernel_wr_addr_i(kernel_wr_addr_i),
    .kernel_wr_data_i(kernel_wr_data_i),
    .kernel_busy_o   (kernel_busy_o),
    .window_valid_i  (window_valid_i),
    .window_ready_o  (window_ready_o),
    .window_data_i   (window_data_i),
    .mac_in_valid_o  (mac_in_valid_o),
    .mac_in_ready_i  (mac_in_ready_i),
    .mac_feature_o   (mac_feature_o),
    .mac_weight_o    (mac_weight_o),
    .mac_last_o      (mac_last_o),
    .mac_valid_i     (mac_valid_i),
    .mac_data_i      (mac_data_i),
    .mac_ready_o     (mac_ready_o),
    .result_valid_o  (result_valid_o),
    .result_data_o   (result_data_o),
    .result_ready_i  (result_ready_i)
  );

  typedef struct packed {
    logic [DW-1:0] f;
    logic [DW-1:0] w;
    logic          last;
  } op_t;

  int n_cmp = 0;
  int n_err = 0;

  op_t            exp_ops[$];
  logic [ACC-1:0] exp_res[$];
  int             kern[K];

  int KERN_A[K] = '{1, 2, 3, 4, 5, -6, 7, 8, 9};
  int WIN_A[K]  = '{1, 2, -3, 4, 5, 6, 7, 8, 9};
  int KERN_B[K] = '{1, 0, 0, 0, 0, 0, 0, 0, 0};
  int WIN_B[K]  = '{1, 0, 0, 0, 0, 0, 0, 0, 0};

  // MAC model state
  logic signed [ACC-1:0] acc = '0;
  logic signed [DW-1:0]  fs, ws;
  int  beats = 0, stall_cnt = 0, lat = 0, cyc = 0, first_cyc = 0, last_span = 0;
  bit  pending = 0, res_active = 0, stall_mode = 0, stale_en = 0;

  task automatic check(input string name, input logic [ACC-1:0] act, input logic [ACC-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_event(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s: event occurred, none expected", name);
  endtask

  // Behavioural MAC: accumulates accepted beats, answers two cycles after the last one.
  initial begin
    forever begin
      @(negedge clk_i);
      cyc++;
      if (!rst_ni) begin
        beats = 0; acc = '0; pending = 0; res_active = 0; stall_cnt = 0;
      end else begin
        if (mac_in_valid_o && mac_in_ready_i) begin
          if (beats == 0) first_cyc = cyc;
          fs = mac_feature_o;
          ws = mac_weight_o;
          acc = acc + fs * ws;
          beats++;
          stall_cnt = 0;
          if (mac_last_o) begin
            pending = 1; lat = 2; last_span = cyc - first_cyc + 1;
          end
        end
        if (mac_valid_i && mac_ready_o && res_active) begin
          res_active = 0; acc = '0; beats = 0;
        end
      end
      @(posedge clk_i);
      #1;
      if (stall_mode && (beats == 2 || beats == 6) && stall_cnt < 2) begin
        mac_in_ready_i = 1'b0;
        stall_cnt++;
      end else begin
        mac_in_ready_i = 1'b1;
      end
      if (pending) begin
        if (lat > 0) lat--;
        else begin pending = 0; res_active = 1; end
      end
      mac_valid_i = res_active || stale_en;
      mac_data_i  = stale_en ? 32'h0000_DEAD : acc;
    end
  end

  // Operand monitor: every accepted beat against the expected queue, plus hold-while-stalled.
  initial begin
    bit  held;
    op_t hv, e;
    held = 0;
    forever begin
      @(negedge clk_i);
      if (!rst_ni) begin
        held = 0;
      end else if (mac_in_valid_o) begin
        if (held) begin
          check("stall_hold_feature", mac_feature_o, hv.f);
          check("stall_hold_weight", mac_weight_o, hv.w);
          check("stall_hold_last", mac_last_o, hv.last);
        end
        if (mac_in_ready_i) begin
          if (exp_ops.size() == 0) fail_event("unexpected_operand");
          else begin
            e = exp_ops.pop_front();
            check("operand_feature", mac_feature_o, e.f);
            check("operand_weight", mac_weight_o, e.w);
            check("operand_last", mac_last_o, e.last);
          end
          held = 0;
        end else begin
          held = 1;
          hv = '{f: mac_feature_o, w: mac_weight_o, last: mac_last_o};
        end
      end else begin
        if (held) fail_event("valid_dropped_while_stalled");
        held = 0;
      end
    end
  end

  // Result monitor
  initial begin
    forever begin
      @(negedge clk_i);
      if (rst_ni && result_valid_o && result_ready_i) begin
        if (exp_res.size() == 0) fail_event("unexpected_result");
        else check("result_data", result_data_o, exp_res.pop_front());
      end
    end
  end

  task automatic write_kernel(input int addr, input int data);
    @(posedge clk_i); #1;
    kernel_wr_en_i   = 1'b1;
    kernel_wr_addr_i = addr[AW:0];
    kernel_wr_data_i = data;
    @(posedge clk_i); #1;
    kernel_wr_en_i = 1'b0;
  endtask

  task automatic load_kernel(input int w[K], input int b);
    for (int i = 0; i < K; i++) write_kernel(i, w[i]);
    write_kernel(K, b);
    kern = w;
  endtask

  task automatic start_window(input int win[K], input logic [ACC-1:0] expv);
    bit got;
    got = 0;
    for (int i = 0; i < K; i++)
      exp_ops.push_back('{f: DW'(win[i]), w: DW'(kern[i]), last: (i == K - 1)});
    exp_res.push_back(expv);
    @(posedge clk_i); #1;
    window_valid_i = 1'b1;
    for (int i = 0; i < K; i++) window_data_i[i*DW +: DW] = DW'(win[i]);
    repeat (50) begin
      @(negedge clk_i);
      if (window_ready_o) begin got = 1; break; end
    end
    check("window_accept_in_time", got, 1);
    @(posedge clk_i); #1;
    window_valid_i = 1'b0;
    @(negedge clk_i);
    check("first_operand_latency", mac_in_valid_o, 1);
  endtask

  task automatic wait_done();
    bit got;
    got = 0;
    repeat (300) begin
      @(posedge clk_i);
      if (exp_res.size() == 0) begin got = 1; break; end
    end
    #1;
    check("result_in_time", got, 1);
    check("operands_all_seen", exp_ops.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit got;
    for (int i = 0; i < K; i++) kern[i] = 0;

    // Reset state
    repeat (3) @(negedge clk_i);
    check("rst_window_ready", window_ready_o, 1);
    check("rst_busy", kernel_busy_o, 0);
    check("rst_mac_in_valid", mac_in_valid_o, 0);
    check("rst_mac_ready", mac_ready_o, 0);
    check("rst_result_valid", result_valid_o, 0);
    check("rst_result_data", result_data_o, 0);
    check("rst_feature", mac_feature_o, 0);
    check("rst_weight", mac_weight_o, 0);
    @(posedge clk_i); #1;
    rst_ni = 1'b1;

    // Basic window, plus an out-of-range write that must be ignored
    load_kernel(KERN_A, 100);
    write_kernel(10, 999);
    start_window(WIN_A, 32'd295);
    wait_done();
    check("beat_span_no_stall", last_span, 9);

    // Back-pressure on beats 3 and 7
    stall_mode = 1;
    start_window(WIN_A, 32'd295);
    wait_done();
    stall_mode = 0;

    // Downstream stall on the result
    result_ready_i = 1'b0;
    start_window(WIN_A, 32'd295);
    got = 0;
    repeat (100) begin
      @(negedge clk_i);
      if (result_valid_o) begin got = 1; break; end
    end
    check("result_valid_in_time", got, 1);
    repeat (5) begin
      @(negedge clk_i);
      check("held_result_valid", result_valid_o, 1);
      check("held_result_data", result_data_o, 32'd295);
      check("held_window_ready", window_ready_o, 0);
    end
    @(posedge clk_i); #1;
    result_ready_i = 1'b1;
    wait_done();
    @(negedge clk_i);
    check("window_ready_after_result", window_ready_o, 1);

    // Kernel write while busy is dropped; the same write in IDLE lands
    start_window(WIN_A, 32'd295);
    check("busy_during_stream", kernel_busy_o, 1);
    write_kernel(0, 50);
    wait_done();
    write_kernel(0, 50);
    kern[0] = 50;
    start_window(WIN_A, 32'd344);
    wait_done();

    // Bias wrap-around
    load_kernel(KERN_B, 32'h7FFF_FFFF);
    start_window(WIN_B, 32'h8000_0000);
    wait_done();

    // Reset in the middle of streaming
    load_kernel(KERN_A, 100);
    start_window(WIN_A, 32'd295);
    repeat (50) begin
      @(posedge clk_i);
      if (beats >= 3) break;
    end
    #2;
    rst_ni = 1'b0;
    exp_ops.delete();
    exp_res.delete();
    #1;
    check("abort_mac_in_valid", mac_in_valid_o, 0);
    check("abort_window_ready", window_ready_o, 1);
    check("abort_busy", kernel_busy_o, 0);
    check("abort_mac_ready", mac_ready_o, 0);
    check("abort_result_valid", result_valid_o, 0);
    check("abort_feature", mac_feature_o, 0);
    check("abort_weight", mac_weight_o, 0);
    check("abort_last", mac_last_o, 0);
    check("abort_result_data", result_data_o, 0);
    stale_en = 1;
    repeat (2) @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    repeat (4) begin
      @(negedge clk_i);
      check("stale_mac_ready", mac_ready_o, 0);
      check("stale_result_valid", result_valid_o, 0);
    end
    stale_en = 0;
    load_kernel(KERN_A, 100);
    start_window(WIN_A, 32'd295);
    wait_done();

    repeat (3) @(posedge clk_i);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
